// File: rtl/clutter_sweep_scheduler.sv
// Per-trigger range sweep sequencer: tracks antenna azimuth and issues one request per range bin.
// Optional sector blanking is compiled in with `define SECTOR_BLANK_EN.
module clutter_sweep_scheduler #(
  parameter int unsigned BIN_COUNT = 256,
  parameter int unsigned BIN_W     = 8,
  parameter int unsigned BIN_GAP   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic             acp,
  input  logic             arp,
  input  logic             req_ready,
`ifdef SECTOR_BLANK_EN
  input  logic [11:0]      sector_start,
  input  logic [11:0]      sector_end,
  output logic             skipped,
`endif
  output logic             req_valid,
  output logic [BIN_W-1:0] req_bin,
  output logic [11:0]      req_az,
  output logic             req_last,
  output logic             sweep_active,
  output logic             synced,
  output logic             overrun,
  output logic [7:0]       overrun_cnt
);

  localparam int unsigned GapW = (BIN_GAP > 0) ? $clog2(BIN_GAP + 1) : 1;
  localparam logic [BIN_W-1:0] LastBin = BIN_W'(BIN_COUNT - 1);
  localparam logic [GapW-1:0] GapLoad = GapW'(BIN_GAP);

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  state_e state_q, state_d;
  logic trig_q, acp_q, arp_q;
  logic [11:0] az_q, az_d, az_lat_q, az_lat_d;
  logic synced_q, synced_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic ovr_q, ovr_d, skip_q, skip_d;
  logic [7:0] ovr_cnt_q, ovr_cnt_d;

  logic trig_edge, acp_edge, arp_edge, in_window, idle_trig, start_sweep, handshake, last_hs;

  assign trig_edge = trig & ~trig_q;
  assign acp_edge  = acp & ~acp_q;
  assign arp_edge  = arp & ~arp_q;

`ifdef SECTOR_BLANK_EN
  // Window wraps through zero when start > end.
  assign in_window = (sector_start <= sector_end) ?
                     ((az_q >= sector_start) && (az_q <= sector_end)) :
                     ((az_q >= sector_start) || (az_q <= sector_end));
`else
  assign in_window = 1'b1;
`endif

  assign idle_trig   = (state_q == StIdle) && trig_edge && synced_q;
  assign start_sweep = idle_trig && in_window;
  assign handshake   = req_valid && req_ready;
  assign last_hs     = handshake && (bin_q == LastBin);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_sweep) state_d = StSweep;
      StSweep: if (last_hs)     state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    az_d = az_q;
    if (arp_edge) begin
      az_d = 12'd0;
    end else if (acp_edge) begin
      az_d = az_q + 12'd1;
    end
    synced_d = synced_q | arp_edge;
    az_lat_d = start_sweep ? az_q : az_lat_q;

    bin_d = bin_q;
    gap_d = gap_q;
    if (start_sweep) begin
      bin_d = '0;
      gap_d = '0;
    end else if (handshake) begin
      bin_d = last_hs ? '0 : bin_q + BIN_W'(1);
      gap_d = last_hs ? '0 : GapLoad;
    end else if (gap_q != '0) begin
      gap_d = gap_q - GapW'(1);
    end

    // The final-handshake cycle is still StSweep, so a coincident trigger is an overrun.
    ovr_d     = trig_edge && (state_q == StSweep);
    ovr_cnt_d = (ovr_d && (ovr_cnt_q != 8'hff)) ? ovr_cnt_q + 8'd1 : ovr_cnt_q;
    skip_d    = idle_trig && !in_window;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_q    <= 1'b0;
      acp_q     <= 1'b0;
      arp_q     <= 1'b0;
      az_q      <= 12'd0;
      az_lat_q  <= 12'd0;
      synced_q  <= 1'b0;
      bin_q     <= '0;
      gap_q     <= '0;
      ovr_q     <= 1'b0;
      ovr_cnt_q <= 8'd0;
      skip_q    <= 1'b0;
    end else begin
      trig_q    <= trig;
      acp_q     <= acp;
      arp_q     <= arp;
      az_q      <= az_d;
      az_lat_q  <= az_lat_d;
      synced_q  <= synced_d;
      bin_q     <= bin_d;
      gap_q     <= gap_d;
      ovr_q     <= ovr_d;
      ovr_cnt_q <= ovr_cnt_d;
      skip_q    <= skip_d;
    end
  end

  always_comb begin
    sweep_active = (state_q == StSweep);
    req_valid    = sweep_active && (gap_q == '0);
    req_last     = req_valid && (bin_q == LastBin);
    req_bin      = bin_q;
    req_az       = az_lat_q;
    synced       = synced_q;
    overrun      = ovr_q;
    overrun_cnt  = ovr_cnt_q;
`ifdef SECTOR_BLANK_EN
    skipped      = skip_q;
`endif
  end

`ifndef SECTOR_BLANK_EN
  logic unused_skip;
  assign unused_skip = skip_q;
`endif

endmodule

// File: doc/clutter_sweep_scheduler.md
# clutter_sweep_scheduler

Sequences the per-trigger range sweep of the sea-clutter datapath. Watches the radar timing outputs (master trigger, ACP, ARP) and tracks antenna azimuth. On every accepted trigger it issues one clutter-sample request per range bin to the clutter generator over a valid/ready handshake, tagging each request with the latched azimuth. Sits between the radar timing block and the clutter generator, all on the 50 MHz system clock.

## Interface
Parameters:
- BIN_COUNT, 256: range bins per sweep; legal range 2..2^BIN_W.
- BIN_W, 8: width of the bin index.
- BIN_GAP, 4: idle cycles forced after each accepted request; 0 allows back-to-back requests.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- trig  in  1  master trigger level from the radar timing block.
- acp  in  1  azimuth change pulse level.
- arp  in  1  azimuth reset pulse level.
- req_ready  in  1  clutter generator accepts the current request.
- req_valid  out  1  request presented.
- req_bin  out  BIN_W  range bin index of the request.
- req_az  out  12  azimuth latched at the trigger edge.
- req_last  out  1  high with the request for bin BIN_COUNT-1.
- sweep_active  out  1  high while in SWEEP.
- synced  out  1  at least one ARP rising edge has been seen since reset.
- overrun  out  1  one-cycle pulse: a trigger edge was dropped because a sweep was in progress.
- overrun_cnt  out  8  count of overruns, saturates at 255.

## Operation
- Edge detect: each of trig, acp and arp is registered once. An edge is the input sampled high with the previous sample low.
- Azimuth counter, 12 bits:
  - ACP edge increments it, wrapping 4095→0.
  - ARP edge forces it to 0. ARP has priority over a simultaneous ACP edge.
  - The first ARP edge sets synced, which stays high until reset.
- States: IDLE, SWEEP.
  - IDLE: a trig edge with synced=1 latches the azimuth into req_az, sets bin=0 and moves to SWEEP. A trig edge with synced=0 is ignored and does not count as an overrun.
  - SWEEP: req_valid=1 when the gap counter is 0.
    - A handshake (req_valid & req_ready) loads the gap counter with BIN_GAP and increments bin.
    - A handshake at bin BIN_COUNT-1 returns the block to IDLE.
- Handshake rule: while req_valid=1 and req_ready=0, req_bin, req_az and req_last stay stable and req_valid stays high.
- A trig edge during SWEEP:
  - pulses overrun;
  - increments overrun_cnt, saturating;
  - leaves the sweep and the latched azimuth untouched.
- A trig edge in the same cycle as the final handshake counts as an overrun; a sweep is never restarted in the cycle it ends.
- The azimuth keeps tracking during a sweep. req_az does not change mid-sweep.

## Timing
- Reset values: all outputs 0, state IDLE, azimuth 0, synced 0, gap counter 0.
- Reset mid-sweep: everything returns to reset values immediately (asynchronous). The block needs a new ARP edge before it will sweep again.
- Trigger to first request: trig sampled high at clock edge k (low at k-1) gives req_valid=1, req_bin=0 and sweep_active=1 after edge k.
- Request spacing: a handshake at edge k gives req_valid=0 for cycles k+1..k+BIN_GAP. The next request is valid after edge k+BIN_GAP; with BIN_GAP=0 it is valid directly after edge k.
- Minimum sweep duration: BIN_COUNT + (BIN_COUNT-1)·BIN_GAP cycles with req_ready tied high.
- Sweep end: sweep_active falls after the edge carrying the final handshake.
- overrun is high for exactly the one cycle after the edge at which the dropped trig edge was sampled.

## Configuration
- SECTOR_BLANK_EN defined:
  - adds inputs sector_start[11:0] and sector_end[11:0], plus output skipped (1-cycle pulse).
  - A synced trig edge in IDLE starts a sweep only if the current azimuth is inside [sector_start, sector_end] inclusive. The window wraps when sector_start > sector_end.
  - Otherwise the block pulses skipped and stays in IDLE.
- SECTOR_BLANK_EN undefined: these ports and the skipped output do not exist, and every synced idle trigger starts a sweep.

## Test plan
- No ARP after reset, 3 trig edges → no req_valid; synced=0, overrun_cnt=0.
- ARP edge, 5 ACP edges, trig edge, req_ready=1, BIN_COUNT=8, BIN_GAP=2 → 8 requests, bins 0..7, req_az=5, each spaced 3 cycles; req_last only on bin 7; sweep lasts 22 cycles.
- req_ready held low 10 cycles at bin 3 → req_valid, req_bin=3 and req_az stable throughout; the sweep resumes at bin 4 after acceptance.
- Second trig edge mid-sweep → one overrun pulse, overrun_cnt=1, sweep completes unchanged; after 260 overruns, overrun_cnt=255.
- Azimuth 4095 then ACP edge → 0; simultaneous ARP and ACP edges at azimuth 100 → 0; rst asserted mid-sweep → req_valid=0 and synced=0 immediately.
- SECTOR_BLANK_EN with sector_start=4000 and sector_end=10: trig at azimuth 5 → sweep; trig at azimuth 500 → skipped pulse, no requests.
